// File: rtl/command_sequencer.sv
// Round-robin arbiter and serializer for one 5-bit command register link.
// Each grant sends the frame 1,0,1,c1,c0. Delivery is confirmed from the register's ready decode.
module command_sequencer #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ACK_WINDOW = 2,
    parameter int unsigned MAX_RETRY  = 2,
    parameter int unsigned GAP_CYCLES = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [2*NUM_REQ-1:0] cmd,
    output logic [NUM_REQ-1:0]   ack,
    output logic [NUM_REQ-1:0]   nack,
    output logic                 busy,
    output logic                 data,
    output logic                 receive,
    input  logic                 empty,
    input  logic                 ready
);
    localparam int unsigned IdxW   = $clog2(NUM_REQ);
    localparam int unsigned MaxCnt = (GAP_CYCLES > ACK_WINDOW) ? GAP_CYCLES : ACK_WINDOW;
    localparam int unsigned CntW   = $clog2(MaxCnt + 1);

    typedef enum logic [2:0] {StIdle, StWaitEmpty, StSend, StCheck, StGap} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [IdxW-1:0]     idx_q, idx_d, rr_q, rr_d;
    logic [1:0]          cmd_q, cmd_d;
    logic [2:0]          retry_q, retry_d;
    logic                retry_pend_q, retry_pend_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d, nack_q, nack_d;
    logic                grant_vld;
    logic [IdxW-1:0]     grant_idx;
    logic [IdxW-1:0]     rr_next;
    logic [1:0]          cmd_sel;
    logic [4:0]          frame;

    // First active request at or after the round-robin pointer.
    always_comb begin
        logic [31:0] pos;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            pos = (32'(rr_q) + k) % NUM_REQ;
            if (!grant_vld && req[pos[IdxW-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = pos[IdxW-1:0];
            end
        end
    end

    assign cmd_sel = cmd[{grant_idx, 1'b0} +: 2];
    assign rr_next = (idx_q == IdxW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
    assign frame   = {3'b101, cmd_q};
    assign ack     = ack_q;
    assign nack    = nack_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        rr_d         = rr_q;
        cmd_d        = cmd_q;
        retry_d      = retry_q;
        retry_pend_d = retry_pend_q;
        ack_d        = '0;
        nack_d       = '0;
        busy         = (state_q != StIdle);
        data         = 1'b0;
        receive      = 1'b0;
        case (state_q)
            StIdle: begin
                retry_d      = '0;
                retry_pend_d = 1'b0;
                if (grant_vld) begin
                    idx_d   = grant_idx;
                    cmd_d   = cmd_sel;
                    state_d = StWaitEmpty;
                end
            end
            StWaitEmpty: begin
                if (empty) begin
                    cnt_d   = '0;
                    state_d = StSend;
                end
            end
            StSend: begin
                receive = 1'b1;
                data    = frame[3'd4 - cnt_q[2:0]];
                if (cnt_q == CntW'(4)) begin
                    cnt_d   = '0;
                    state_d = StCheck;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StCheck: begin
                if (ready) begin
                    ack_d[idx_q] = 1'b1;
                    rr_d         = rr_next;
                    cnt_d        = '0;
                    state_d      = StGap;
                end else if (cnt_q == CntW'(ACK_WINDOW - 1)) begin
                    if (retry_q < 3'(MAX_RETRY)) begin
                        retry_d      = retry_q + 3'd1;
                        retry_pend_d = 1'b1;
                    end else begin
                        nack_d[idx_q] = 1'b1;
                        rr_d          = rr_next;
                    end
                    cnt_d   = '0;
                    state_d = StGap;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StGap: begin
                // Idle long enough that the register's sliding decode cannot alias a new frame.
                if (cnt_q == CntW'(GAP_CYCLES - 1)) begin
                    cnt_d        = '0;
                    retry_pend_d = 1'b0;
                    state_d      = retry_pend_q ? StWaitEmpty : StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            idx_q        <= '0;
            rr_q         <= '0;
            cmd_q        <= '0;
            retry_q      <= '0;
            retry_pend_q <= 1'b0;
            ack_q        <= '0;
            nack_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            rr_q         <= rr_d;
            cmd_q        <= cmd_d;
            retry_q      <= retry_d;
            retry_pend_q <= retry_pend_d;
            ack_q        <= ack_d;
            nack_q       <= nack_d;
        end
    end
endmodule
